// File: rtl/axi4lite_arbiter_2to1.sv
// Two-master to one-slave AXI4-Lite arbiter: one whole transaction at a time,
// round-robin between masters, write before read within the granted master.
module axi4lite_arbiter_2to1 #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              aclk,
    input  logic              areset,

    input  logic [ADDR_W-1:0] m0_awaddr,
    input  logic              m0_awvalid,
    output logic              m0_awready,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_wvalid,
    output logic              m0_wready,
    output logic [1:0]        m0_bresp,
    output logic              m0_bvalid,
    input  logic              m0_bready,
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    output logic              m0_rvalid,
    input  logic              m0_rready,

    input  logic [ADDR_W-1:0] m1_awaddr,
    input  logic              m1_awvalid,
    output logic              m1_awready,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_wvalid,
    output logic              m1_wready,
    output logic [1:0]        m1_bresp,
    output logic              m1_bvalid,
    input  logic              m1_bready,
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    output logic              m1_rvalid,
    input  logic              m1_rready,

    output logic [ADDR_W-1:0] s_awaddr,
    output logic              s_awvalid,
    input  logic              s_awready,
    output logic [DATA_W-1:0] s_wdata,
    output logic              s_wvalid,
    input  logic              s_wready,
    input  logic [1:0]        s_bresp,
    input  logic              s_bvalid,
    output logic              s_bready,
    output logic [ADDR_W-1:0] s_araddr,
    output logic              s_arvalid,
    input  logic              s_arready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rvalid,
    output logic              s_rready,

    output logic [1:0]        gnt,
    output logic              busy
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_REQ  = 3'd1;
    localparam logic [2:0] ST_WR_RESP = 3'd2;
    localparam logic [2:0] ST_RD_REQ  = 3'd3;
    localparam logic [2:0] ST_RD_RESP = 3'd4;

    logic [2:0] state, state_nxt;
    logic       sel, sel_nxt;
    logic       prio, prio_nxt;
    logic       aw_done, aw_done_nxt;
    logic       w_done, w_done_nxt;
    logic [1:0] gnt_nxt;
    logic       pick;

    logic wr0, wr1, req0, req1;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    logic [ADDR_W-1:0] sel_awaddr, sel_araddr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_awvalid, sel_wvalid, sel_bready, sel_arvalid, sel_rready;

    logic              fwd_awready, fwd_wready, fwd_bvalid, fwd_arready, fwd_rvalid;
    logic [1:0]        fwd_bresp, fwd_rresp;
    logic [DATA_W-1:0] fwd_rdata;

    assign wr0  = m0_awvalid & m0_wvalid;
    assign wr1  = m1_awvalid & m1_wvalid;
    assign req0 = wr0 | m0_arvalid;
    assign req1 = wr1 | m1_arvalid;

    // Granted-master request side
    assign sel_awaddr  = sel ? m1_awaddr  : m0_awaddr;
    assign sel_awvalid = sel ? m1_awvalid : m0_awvalid;
    assign sel_wdata   = sel ? m1_wdata   : m0_wdata;
    assign sel_wvalid  = sel ? m1_wvalid  : m0_wvalid;
    assign sel_bready  = sel ? m1_bready  : m0_bready;
    assign sel_araddr  = sel ? m1_araddr  : m0_araddr;
    assign sel_arvalid = sel ? m1_arvalid : m0_arvalid;
    assign sel_rready  = sel ? m1_rready  : m0_rready;

    assign aw_hs = s_awvalid & s_awready;
    assign w_hs  = s_wvalid  & s_wready;
    assign b_hs  = s_bvalid  & s_bready;
    assign ar_hs = s_arvalid & s_arready;
    assign r_hs  = s_rvalid  & s_rready;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state   <= ST_IDLE;
            sel     <= 1'b0;
            prio    <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            gnt     <= 2'b00;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            sel     <= sel_nxt;
            prio    <= prio_nxt;
            aw_done <= aw_done_nxt;
            w_done  <= w_done_nxt;
            gnt     <= gnt_nxt;
            busy    <= (state_nxt != ST_IDLE);
        end
    end

    // Arbitration and transaction sequencing
    always_comb begin
        state_nxt   = state;
        sel_nxt     = sel;
        prio_nxt    = prio;
        aw_done_nxt = aw_done;
        w_done_nxt  = w_done;
        gnt_nxt     = gnt;
        pick        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req0 || req1) begin
                    pick      = (req0 && req1) ? prio : req1;
                    state_nxt = (pick ? wr1 : wr0) ? ST_WR_REQ : ST_RD_REQ;
                    sel_nxt   = pick;
                    gnt_nxt   = pick ? 2'b10 : 2'b01;
                end
            end
            ST_WR_REQ: begin
                aw_done_nxt = aw_done | aw_hs;
                w_done_nxt  = w_done | w_hs;
                if (aw_done_nxt && w_done_nxt) begin
                    state_nxt = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (b_hs) begin
                    state_nxt   = ST_IDLE;
                    prio_nxt    = ~sel;
                    gnt_nxt     = 2'b00;
                    aw_done_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                end
            end
            ST_RD_REQ: begin
                if (ar_hs) begin
                    state_nxt = ST_RD_RESP;
                end
            end
            ST_RD_RESP: begin
                if (r_hs) begin
                    state_nxt   = ST_IDLE;
                    prio_nxt    = ~sel;
                    gnt_nxt     = 2'b00;
                    aw_done_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt   = ST_IDLE;
                gnt_nxt     = 2'b00;
                aw_done_nxt = 1'b0;
                w_done_nxt  = 1'b0;
            end
        endcase
    end

    // Channel forwarding; completed AW/W channels are masked off
    always_comb begin
        s_awaddr    = '0;
        s_awvalid   = 1'b0;
        s_wdata     = '0;
        s_wvalid    = 1'b0;
        s_bready    = 1'b0;
        s_araddr    = '0;
        s_arvalid   = 1'b0;
        s_rready    = 1'b0;
        fwd_awready = 1'b0;
        fwd_wready  = 1'b0;
        fwd_bvalid  = 1'b0;
        fwd_bresp   = 2'b00;
        fwd_arready = 1'b0;
        fwd_rvalid  = 1'b0;
        fwd_rdata   = '0;
        fwd_rresp   = 2'b00;
        case (state)
            ST_WR_REQ: begin
                s_awaddr    = sel_awaddr;
                s_awvalid   = sel_awvalid & ~aw_done;
                s_wdata     = sel_wdata;
                s_wvalid    = sel_wvalid & ~w_done;
                fwd_awready = s_awready & ~aw_done;
                fwd_wready  = s_wready & ~w_done;
            end
            ST_WR_RESP: begin
                s_bready   = sel_bready;
                fwd_bvalid = s_bvalid;
                fwd_bresp  = s_bresp;
            end
            ST_RD_REQ: begin
                s_araddr    = sel_araddr;
                s_arvalid   = sel_arvalid;
                fwd_arready = s_arready;
            end
            ST_RD_RESP: begin
                s_rready   = sel_rready;
                fwd_rvalid = s_rvalid;
                fwd_rdata  = s_rdata;
                fwd_rresp  = s_rresp;
            end
            default: ;
        endcase
    end

    assign m0_awready = gnt[0] & fwd_awready;
    assign m0_wready  = gnt[0] & fwd_wready;
    assign m0_bvalid  = gnt[0] & fwd_bvalid;
    assign m0_bresp   = gnt[0] ? fwd_bresp : 2'b00;
    assign m0_arready = gnt[0] & fwd_arready;
    assign m0_rvalid  = gnt[0] & fwd_rvalid;
    assign m0_rdata   = gnt[0] ? fwd_rdata : '0;
    assign m0_rresp   = gnt[0] ? fwd_rresp : 2'b00;

    assign m1_awready = gnt[1] & fwd_awready;
    assign m1_wready  = gnt[1] & fwd_wready;
    assign m1_bvalid  = gnt[1] & fwd_bvalid;
    assign m1_bresp   = gnt[1] ? fwd_bresp : 2'b00;
    assign m1_arready = gnt[1] & fwd_arready;
    assign m1_rvalid  = gnt[1] & fwd_rvalid;
    assign m1_rdata   = gnt[1] ? fwd_rdata : '0;
    assign m1_rresp   = gnt[1] ? fwd_rresp : 2'b00;

endmodule

// File: tb/tb_axi4lite_arbiter_2to1.sv
// Directed self-checking bench for axi4lite_arbiter_2to1.
module tb_axi4lite_arbiter_2to1;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic aclk = 1'b0;
    logic areset;

    logic [ADDR_W-1:0] m0_awaddr, m1_awaddr, m0_araddr, m1_araddr, s_awaddr, s_araddr;
    logic [DATA_W-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, s_wdata, s_rdata;
    logic m0_awvalid, m0_awready, m0_wvalid, m0_wready, m0_bvalid, m0_bready;
    logic m0_arvalid, m0_arready, m0_rvalid, m0_rready;
    logic m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
    logic m1_arvalid, m1_arready, m1_rvalid, m1_rready;
    logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic s_arvalid, s_arready, s_rvalid, s_rready;
    logic [1:0] m0_bresp, m0_rresp, m1_bresp, m1_rresp, s_bresp, s_rresp;
    logic [1:0] gnt;
    logic       busy;

    int n_checks = 0;
    int n_fails  = 0;

    axi4lite_arbiter_2to1 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .aclk(aclk), .areset(areset),
        .m0_awaddr(m0_awaddr), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
        .m0_wdata(m0_wdata), .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
        .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
        .m1_wdata(m1_wdata), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
        .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .gnt(gnt), .busy(busy)
    );

    always #5 aclk = ~aclk;

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        m0_awaddr = '0; m0_awvalid = 0; m0_wdata = '0; m0_wvalid = 0; m0_bready = 0;
        m0_araddr = '0; m0_arvalid = 0; m0_rready = 0;
        m1_awaddr = '0; m1_awvalid = 0; m1_wdata = '0; m1_wvalid = 0; m1_bready = 0;
        m1_araddr = '0; m1_arvalid = 0; m1_rready = 0;
        s_awready = 0; s_wready = 0; s_bresp = 2'b00; s_bvalid = 0;
        s_arready = 0; s_rdata = '0; s_rresp = 2'b00; s_rvalid = 0;
    endtask

    initial begin
        clear_inputs();
        areset = 1'b1;
        step();
        step();
        #1;
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_prio", dut.prio, 1'b0);
        chk("rst_s_awvalid", s_awvalid, 1'b0);
        chk("rst_m0_awready", m0_awready, 1'b0);
        areset = 1'b0;

        // Single write from m0
        step();
        m0_awaddr = 32'h10; m0_awvalid = 1; m0_wdata = 32'hDEADBEEF; m0_wvalid = 1;
        s_awready = 1; s_wready = 1;
        #1;
        chk("wr_idle_s_awvalid", s_awvalid, 1'b0);
        step();
        #1;
        chk("wr_gnt", gnt, 2'b01);
        chk("wr_busy", busy, 1'b1);
        chk("wr_s_awvalid", s_awvalid, 1'b1);
        chk("wr_s_awaddr", s_awaddr, 32'h10);
        chk("wr_s_wvalid", s_wvalid, 1'b1);
        chk("wr_s_wdata", s_wdata, 32'hDEADBEEF);
        chk("wr_m0_awready", m0_awready, 1'b1);
        chk("wr_m1_awready", m1_awready, 1'b0);
        step();
        m0_awvalid = 0; m0_wvalid = 0; s_awready = 0; s_wready = 0;
        s_bvalid = 1; s_bresp = 2'b00; m0_bready = 1;
        #1;
        chk("wr_m0_bvalid", m0_bvalid, 1'b1);
        chk("wr_m0_bresp", m0_bresp, 2'b00);
        chk("wr_s_bready", s_bready, 1'b1);
        chk("wr_resp_s_awvalid", s_awvalid, 1'b0);
        step();
        s_bvalid = 0; m0_bready = 0;
        #1;
        chk("wr_done_gnt", gnt, 2'b00);
        chk("wr_done_busy", busy, 1'b0);
        chk("wr_done_prio", dut.prio, 1'b1);
        chk("wr_done_m0_bvalid", m0_bvalid, 1'b0);

        // Contention: reset pointer to m0, both masters hold writes
        areset = 1'b1;
        step();
        areset = 1'b0;
        m0_awaddr = 32'h0; m0_awvalid = 1; m0_wdata = 32'h1111; m0_wvalid = 1; m0_bready = 1;
        m1_awaddr = 32'h4; m1_awvalid = 1; m1_wdata = 32'h2222; m1_wvalid = 1; m1_bready = 1;
        s_awready = 1; s_wready = 1; s_bvalid = 1; s_bresp = 2'b10;
        for (int k = 0; k < 4; k++) begin
            step();
            #1;
            chk("ct_gnt", gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("ct_s_awaddr", s_awaddr, (k % 2 == 0) ? 32'h0 : 32'h4);
            chk("ct_other_awready", (k % 2 == 0) ? m1_awready : m0_awready, 1'b0);
            step();
            #1;
            chk("ct_bvalid", (k % 2 == 0) ? m0_bvalid : m1_bvalid, 1'b1);
            chk("ct_bresp", (k % 2 == 0) ? m0_bresp : m1_bresp, 2'b10);
            chk("ct_other_bresp", (k % 2 == 0) ? m1_bresp : m0_bresp, 2'b00);
            step();
            #1;
            chk("ct_bubble_gnt", gnt, 2'b00);
            chk("ct_bubble_busy", busy, 1'b0);
        end
        clear_inputs();
        chk("ct_prio", dut.prio, 1'b0);

        // Split AW/W acceptance; m0 keeps awvalid up to prove masking
        m0_awaddr = 32'h30; m0_awvalid = 1; m0_wdata = 32'hCAFEF00D; m0_wvalid = 1;
        step();
        #1;
        chk("sp_c0_s_awvalid", s_awvalid, 1'b1);
        chk("sp_c0_s_wvalid", s_wvalid, 1'b1);
        step();
        s_awready = 1;
        #1;
        chk("sp_c1_m0_awready", m0_awready, 1'b1);
        step();
        #1;
        chk("sp_c2_s_awvalid", s_awvalid, 1'b0);
        chk("sp_c2_m0_awready", m0_awready, 1'b0);
        chk("sp_c2_s_wvalid", s_wvalid, 1'b1);
        chk("sp_c2_busy", busy, 1'b1);
        step();
        #1;
        chk("sp_c3_s_wvalid", s_wvalid, 1'b1);
        chk("sp_c3_s_awvalid", s_awvalid, 1'b0);
        step();
        s_wready = 1;
        #1;
        chk("sp_c4_m0_wready", m0_wready, 1'b1);
        step();
        m0_awvalid = 0; m0_wvalid = 0; s_awready = 0; s_wready = 0;
        s_bvalid = 1; s_bresp = 2'b00; m0_bready = 1;
        #1;
        chk("sp_resp_m0_bvalid", m0_bvalid, 1'b1);
        chk("sp_resp_s_wvalid", s_wvalid, 1'b0);
        step();
        clear_inputs();
        #1;
        chk("sp_done_gnt", gnt, 2'b00);
        chk("sp_done_prio", dut.prio, 1'b1);

        // Read from m1 with response backpressure
        m1_araddr = 32'h20; m1_arvalid = 1; s_arready = 1;
        step();
        #1;
        chk("rd_gnt", gnt, 2'b10);
        chk("rd_s_arvalid", s_arvalid, 1'b1);
        chk("rd_s_araddr", s_araddr, 32'h20);
        chk("rd_m1_arready", m1_arready, 1'b1);
        chk("rd_m0_arready", m0_arready, 1'b0);
        step();
        m1_arvalid = 0; s_arready = 0;
        s_rvalid = 1; s_rdata = 32'h12345678; s_rresp = 2'b00; m1_rready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rd_bp_m1_rvalid", m1_rvalid, 1'b1);
            chk("rd_bp_m1_rdata", m1_rdata, 32'h12345678);
            chk("rd_bp_s_rready", s_rready, 1'b0);
            chk("rd_bp_busy", busy, 1'b1);
            chk("rd_bp_m0_rdata", m0_rdata, 32'h0);
            step();
        end
        m1_rready = 1;
        #1;
        chk("rd_s_rready", s_rready, 1'b1);
        step();
        clear_inputs();
        #1;
        chk("rd_done_busy", busy, 1'b0);
        chk("rd_done_m1_rvalid", m1_rvalid, 1'b0);
        chk("rd_done_prio", dut.prio, 1'b0);

        // Write-over-read within m0
        m0_araddr = 32'h40; m0_arvalid = 1;
        m0_awaddr = 32'h44; m0_awvalid = 1; m0_wdata = 32'h55AA; m0_wvalid = 1;
        m0_bready = 1; m0_rready = 1;
        s_awready = 1; s_wready = 1; s_arready = 1;
        s_bvalid = 1; s_rvalid = 1; s_rdata = 32'hA5A5; s_rresp = 2'b10;
        step();
        #1;
        chk("wor_gnt", gnt, 2'b01);
        chk("wor_s_awvalid", s_awvalid, 1'b1);
        chk("wor_s_arvalid", s_arvalid, 1'b0);
        step();
        m0_awvalid = 0; m0_wvalid = 0;
        #1;
        chk("wor_m0_bvalid", m0_bvalid, 1'b1);
        chk("wor_m0_rvalid_in_wr", m0_rvalid, 1'b0);
        step();
        #1;
        chk("wor_bubble_gnt", gnt, 2'b00);
        chk("wor_bubble_prio", dut.prio, 1'b1);
        step();
        #1;
        chk("wor_rd_gnt", gnt, 2'b01);
        chk("wor_rd_s_arvalid", s_arvalid, 1'b1);
        chk("wor_rd_s_araddr", s_araddr, 32'h40);
        step();
        m0_arvalid = 0;
        #1;
        chk("wor_m0_rvalid", m0_rvalid, 1'b1);
        chk("wor_m0_rdata", m0_rdata, 32'hA5A5);
        chk("wor_m0_rresp", m0_rresp, 2'b10);
        step();
        clear_inputs();
        #1;
        chk("wor_done_busy", busy, 1'b0);
        chk("wor_done_prio", dut.prio, 1'b1);

        // Reset during WR_RESP of an m1 write
        m1_awaddr = 32'h8; m1_awvalid = 1; m1_wdata = 32'h77; m1_wvalid = 1;
        s_awready = 1; s_wready = 1;
        step();
        step();
        m1_awvalid = 0; m1_wvalid = 0; s_awready = 0; s_wready = 0;
        s_bvalid = 1; m1_bready = 0;
        #1;
        chk("rm_pre_busy", busy, 1'b1);
        chk("rm_pre_gnt", gnt, 2'b10);
        chk("rm_pre_m1_bvalid", m1_bvalid, 1'b1);
        areset = 1'b1;
        step();
        areset = 1'b0;
        #1;
        chk("rm_busy", busy, 1'b0);
        chk("rm_gnt", gnt, 2'b00);
        chk("rm_prio", dut.prio, 1'b0);
        chk("rm_m1_bvalid", m1_bvalid, 1'b0);
        chk("rm_s_bready", s_bready, 1'b0);
        chk("rm_s_awvalid", s_awvalid, 1'b0);
        clear_inputs();
        step();
        #1;
        chk("rm_idle_busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/axi4lite_arbiter_2to1.md
Name: axi4lite_arbiter_2to1

Overview:
- Shares one AXI4-Lite slave port between two AXI4-Lite masters (m0, m1).
- Sits in front of the NoC-side AXI4-Lite slave, e.g. a host interface and a router-side master both accessing one FIFO/register slave.
- Grants one complete transaction (read or write) at a time.
- Round-robin between masters; write-over-read priority within a master; registered grant FSM.

Parameters:
- ADDR_W, 32, address width of all AW/AR channels
- DATA_W, 32, data width of all W/R channels

Ports:
- aclk  input  1  clock, all logic on rising edge
- areset  input  1  synchronous, active-high reset
- m0_*/m1_* (two identical master-facing bundles; "mX" below):
  - mX_awaddr  input  ADDR_W  write address
  - mX_awvalid  input  1
  - mX_awready  output  1
  - mX_wdata  input  DATA_W
  - mX_wvalid  input  1
  - mX_wready  output  1
  - mX_bresp  output  2
  - mX_bvalid  output  1
  - mX_bready  input  1
  - mX_araddr  input  ADDR_W
  - mX_arvalid  input  1
  - mX_arready  output  1
  - mX_rdata  output  DATA_W
  - mX_rresp  output  2
  - mX_rvalid  output  1
  - mX_rready  input  1
- s_* (slave-facing bundle, same 16 signals with directions reversed, e.g. s_awaddr output ADDR_W, s_awready input 1, s_rdata input DATA_W)
- gnt  output  2  one-hot granted master (bit0 = m0); 2'b00 when idle
- busy  output  1  high in any state other than IDLE

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock is aclk, reset is areset.
- Requests (sampled in IDLE only):
  - Write request wr_X = mX_awvalid && mX_wvalid; both are required.
  - Read request rd_X = mX_arvalid.
  - req_X = wr_X || rd_X.
- Arbitration in IDLE:
  - Pointer prio (1 bit) names the preferred master.
  - If only one master requests, grant it.
  - If both request, grant prio.
  - Within the granted master, write beats read.
  - Grant, op and state register at the clock edge; forwarding starts the next cycle. Master valid to s_*valid is therefore ≥1 cycle.
- States:
  - IDLE: all s_* valid/ready outputs are 0. All master ready/valid outputs are 0. s_* address/data outputs are 0.
  - WR_REQ: granted master's AW and W channels are forwarded combinationally to s_*.
    - Flags aw_done and w_done set on the respective s_ handshake. A done channel stops forwarding (its valid is masked to 0).
    - Go to WR_RESP when both are done; a same-cycle handshake of both is allowed.
  - WR_RESP: s_bvalid/s_bresp go to the granted master and its mX_bready drives s_bready. On s_bvalid && s_bready, go to IDLE.
  - RD_REQ: forward AR. On s_arvalid && s_arready, go to RD_RESP.
  - RD_RESP: forward R (rdata, rresp, rvalid/rready). On handshake, go to IDLE.
- Completion: on return to IDLE, prio <= the non-granted master, and aw_done/w_done clear.
  - IDLE lasts exactly one cycle when a request is pending. This gives one bubble between transactions.
- Non-granted master: all its ready and valid outputs are held 0 at all times; its bresp/rresp/rdata are 0.
- Request withdrawal: a master must hold valid until its handshake (AXI rule). The arbiter does not re-check requests after the grant.
- No timeout; a stalled slave holds the grant indefinitely.
- Reset values: state = IDLE, prio = m0, gnt = 0, busy = 0, aw_done = w_done = 0. All ready/valid outputs are 0.
- Reset mid-operation: the transaction is abandoned and the block is in IDLE next cycle. The slave and masters are reset concurrently by the same areset.
- Responses are passed through unmodified (OKAY/SLVERR etc.). The arbiter never generates a response itself.

Test Plan:
- Single write:
  - Stimulus: m0 write, awaddr = 0x10, wdata = 0xDEADBEEF; slave awready = wready = 1.
  - Required: s_awvalid high 1 cycle after request with the same addr/data; m0_bvalid mirrors s_bvalid with bresp = 00; gnt = 01 during the transaction, 00 after; prio = m1.
- Simultaneous contention:
  - Stimulus: m0 and m1 both assert writes (addr 0x0 / 0x4) every cycle, held.
  - Required: grant order m0, m1, m0, m1; m1 awready stays 0 while m0 is granted; one IDLE cycle between grants.
- Split AW/W acceptance:
  - Stimulus: slave asserts awready at cycle 1 and wready at cycle 4.
  - Required: s_awvalid drops after the cycle-1 handshake while s_wvalid stays high until cycle 4; WR_RESP is entered after cycle 4; no duplicate AW handshake.
- Read with backpressure:
  - Stimulus: m1 read, araddr = 0x20; slave returns rdata = 0x12345678; m1_rready low for 3 cycles.
  - Required: s_rready follows m1_rready; m1_rvalid is held with stable data; IDLE is entered only on the handshake cycle.
- Write-over-read:
  - Stimulus: m0 asserts arvalid and awvalid+wvalid together, m1 idle.
  - Required: write granted first, read second; prio is m1 after each transaction but m0 is re-granted since m1 is idle.
- Reset mid-transaction:
  - Stimulus: areset high for 1 cycle during WR_RESP.
  - Required: next cycle busy = 0, gnt = 00, all valid/ready = 0, prio = m0.
